// File: rtl/wbu_pkg.sv
// Shared encodings for the write-back-unit CSR sequencer: op codes, CSR addresses,
// FSM states and the latched request payload.
package wbu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CSR_AW = 12;
   localparam int unsigned RD_AW  = 5;
   localparam int unsigned OP_W   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'b000,
      OP_CSRRW = 3'b001,
      OP_CSRRS = 3'b010,
      OP_CSRRC = 3'b011,
      OP_ECALL = 3'b100,
      OP_MRET  = 3'b101
   } op_e;

   localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_OR   = 2'd1,
      ALU_ANDN = 2'd2
   } alu_op_e;

   typedef struct packed {
      op_e               op;
      logic [CSR_AW-1:0] addr;
      logic [XLEN-1:0]   rs1;
      logic [RD_AW-1:0]  rd_idx;
      logic [XLEN-1:0]   pc;
   } req_t;

   // CSR that must be read for a given request; no-op codes read nothing.
   function automatic logic [CSR_AW-1:0] read_addr(input op_e op, input logic [CSR_AW-1:0] addr);
      logic [CSR_AW-1:0] ra;
      ra = '0;
      unique case (op)
         OP_CSRRW, OP_CSRRS, OP_CSRRC: ra = addr;
         OP_ECALL:                     ra = CSR_MTVEC;
         OP_MRET:                      ra = CSR_MEPC;
         default:                      ra = '0;
      endcase
      return ra;
   endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// CSR write-data ALU: pass (csrrw), set bits (csrrs) or clear bits (csrrc).
module csr_wdata_alu
   import wbu_pkg::*;
(
   input  alu_op_e         op_i,
   input  logic [XLEN-1:0] old_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic [XLEN-1:0] wdata_o
);

   always_comb begin
      wdata_o = rs1_i;
      unique case (op_i)
         ALU_OR:   wdata_o = old_i | rs1_i;
         ALU_ANDN: wdata_o = old_i & ~rs1_i;
         default:  wdata_o = rs1_i;
      endcase
   end

endmodule

// File: rtl/wbu_csr_seq.sv
// Three-cycle CSR / ecall / mret sequencer: accept, read the CSR, then commit
// CSR writes, register writeback and fetch redirect in a single cycle.
module wbu_csr_seq
   import wbu_pkg::*;
#(
   parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [OP_W-1:0]     i_op,
   input  logic [CSR_AW-1:0]   i_csr_addr,
   input  logic [XLEN-1:0]     i_rs1_data,
   input  logic [RD_AW-1:0]    i_rd_idx,
   input  logic [XLEN-1:0]     i_pc,
   output logic [CSR_AW-1:0]   o_csr_raddr,
   input  logic [XLEN-1:0]     i_csr_rdata,
   output logic                o_csr_wena1,
   output logic [CSR_AW-1:0]   o_csr_waddr1,
   output logic [XLEN-1:0]     o_csr_wdata1,
   output logic                o_csr_wena2,
   output logic [CSR_AW-1:0]   o_csr_waddr2,
   output logic [XLEN-1:0]     o_csr_wdata2,
   output logic                o_rd_wena,
   output logic [RD_AW-1:0]    o_rd_idx,
   output logic [XLEN-1:0]     o_rd_wdata,
   output logic                o_redirect_valid,
   output logic [XLEN-1:0]     o_redirect_pc,
   output logic                o_done
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic              ready_q, ready_d;
   logic [CSR_AW-1:0] raddr_q, raddr_d;
   logic              wena1_q, wena1_d, wena2_q, wena2_d;
   logic [CSR_AW-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
   logic [XLEN-1:0]   wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic              rd_wena_q, rd_wena_d;
   logic [RD_AW-1:0]  rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]   rd_wdata_q, rd_wdata_d;
   logic              redir_valid_q, redir_valid_d;
   logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
   logic              done_q, done_d;

   alu_op_e           alu_op;
   logic [XLEN-1:0]   alu_wdata;
   logic [XLEN-1:0]   old;

   // CSR read data is combinational and valid during READ, where it is consumed.
   assign old = i_csr_rdata;

   always_comb begin
      alu_op = ALU_PASS;
      unique case (req_q.op)
         OP_CSRRS: alu_op = ALU_OR;
         OP_CSRRC: alu_op = ALU_ANDN;
         default:  alu_op = ALU_PASS;
      endcase
   end

   csr_wdata_alu u_alu (
      .op_i    (alu_op),
      .old_i   (old),
      .rs1_i   (req_q.rs1),
      .wdata_o (alu_wdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         req_q         <= '0;
         ready_q       <= 1'b1;
         raddr_q       <= '0;
         wena1_q       <= 1'b0;
         waddr1_q      <= '0;
         wdata1_q      <= '0;
         wena2_q       <= 1'b0;
         waddr2_q      <= '0;
         wdata2_q      <= '0;
         rd_wena_q     <= 1'b0;
         rd_idx_q      <= '0;
         rd_wdata_q    <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         ready_q       <= ready_d;
         raddr_q       <= raddr_d;
         wena1_q       <= wena1_d;
         waddr1_q      <= waddr1_d;
         wdata1_q      <= wdata1_d;
         wena2_q       <= wena2_d;
         waddr2_q      <= waddr2_d;
         wdata2_q      <= wdata2_d;
         rd_wena_q     <= rd_wena_d;
         rd_idx_q      <= rd_idx_d;
         rd_wdata_q    <= rd_wdata_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         done_q        <= done_d;
      end
   end

   // Commit-cycle outputs are computed during READ so they appear registered in COMMIT.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      ready_d       = ready_q;
      raddr_d       = raddr_q;
      wena1_d       = 1'b0;
      waddr1_d      = '0;
      wdata1_d      = '0;
      wena2_d       = 1'b0;
      waddr2_d      = '0;
      wdata2_d      = '0;
      rd_wena_d     = 1'b0;
      rd_idx_d      = '0;
      rd_wdata_d    = '0;
      redir_valid_d = 1'b0;
      redir_pc_d    = '0;
      done_d        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               req_d.op     = op_e'(i_op);
               req_d.addr   = i_csr_addr;
               req_d.rs1    = i_rs1_data;
               req_d.rd_idx = i_rd_idx;
               req_d.pc     = i_pc;
               raddr_d      = read_addr(op_e'(i_op), i_csr_addr);
               ready_d      = 1'b0;
               state_d      = ST_READ;
            end
         end
         ST_READ: begin
            raddr_d = '0;
            done_d  = 1'b1;
            state_d = ST_COMMIT;
            unique case (req_q.op)
               OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                  wena1_d    = (req_q.op == OP_CSRRW) || (req_q.rs1 != '0);
                  waddr1_d   = req_q.addr;
                  wdata1_d   = alu_wdata;
                  rd_wena_d  = (req_q.rd_idx != '0);
                  rd_idx_d   = req_q.rd_idx;
                  rd_wdata_d = old;
               end
               OP_ECALL: begin
                  wena1_d       = 1'b1;
                  waddr1_d      = CSR_MEPC;
                  wdata1_d      = req_q.pc;
                  wena2_d       = 1'b1;
                  waddr2_d      = CSR_MCAUSE;
                  wdata2_d      = MCAUSE_ECALL;
                  redir_valid_d = 1'b1;
                  redir_pc_d    = {old[XLEN-1:2], 2'b00};
               end
               OP_MRET: begin
                  redir_valid_d = 1'b1;
                  redir_pc_d    = old;
               end
               default: ;
            endcase
         end
         ST_COMMIT: begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            raddr_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_ready          = ready_q;
   assign o_csr_raddr      = raddr_q;
   assign o_csr_wena1      = wena1_q;
   assign o_csr_waddr1     = waddr1_q;
   assign o_csr_wdata1     = wdata1_q;
   assign o_csr_wena2      = wena2_q;
   assign o_csr_waddr2     = waddr2_q;
   assign o_csr_wdata2     = wdata2_q;
   assign o_rd_wena        = rd_wena_q;
   assign o_rd_idx         = rd_idx_q;
   assign o_rd_wdata       = rd_wdata_q;
   assign o_redirect_valid = redir_valid_q;
   assign o_redirect_pc    = redir_pc_q;
   assign o_done           = done_q;

endmodule
